// File: rtl/seq_pattern_gen.sv
// Serial MSB-first pattern transmitter with one-shot/loop modes and a
// start/busy/done handshake; drives the w input of the sequence detectors.
module seq_pattern_gen #(
  parameter int unsigned LEN = 8,
  parameter int unsigned CW  = 5
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [LEN-1:0] Pattern,
  input  logic [CW-1:0]  BitCount,
  input  logic           Loop,
  input  logic           Stop,
  output logic           w,
  output logic           Valid,
  output logic           Busy,
  output logic           Done,
  output logic           Err,
  output logic [1:0]     CurState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [LEN-1:0] shreg_q, shreg_d;
  logic [LEN-1:0] shadow_q, shadow_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  len_q, len_d;
  logic           loop_q, loop_d;
  logic           err_q, err_d;
  logic           cnt_ok;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      err_q    <= err_d;
    end
  end

  // Next-state: load on accepted Start, shift/count in SHIFT, reload when looping
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    loop_d   = loop_q;
    err_d    = 1'b0;
    cnt_ok   = (BitCount != '0) && (BitCount <= CW'(LEN));
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (cnt_ok) begin
            shreg_d  = Pattern;
            shadow_d = Pattern;
            cnt_d    = BitCount;
            len_d    = BitCount;
            loop_d   = Loop;
            state_d  = S_SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CW'(1);
        loop_d  = loop_q & ~Stop;
        if (cnt_q == CW'(1)) begin
          // Stop on the final edge wins over the loop flag
          if (loop_q && !Stop) begin
            shreg_d = shadow_q;
            cnt_d   = len_q;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    w     = 1'b0;
    Valid = 1'b0;
    Busy  = 1'b0;
    Done  = 1'b0;
    case (state_q)
      S_SHIFT: begin
        w     = shreg_q[LEN-1];
        Valid = 1'b1;
        Busy  = 1'b1;
      end
      S_DONE: begin
        Done = 1'b1;
        Busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign Err      = err_q;
  assign CurState = state_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed scenarios plus randomized
// transactions compared cycle by cycle against a bit-stream reference model.
module tb_seq_pattern_gen;

  localparam int unsigned LEN = 8;
  localparam int unsigned CW  = 5;

  logic           clk;
  logic           rst;
  logic           start;
  logic [LEN-1:0] pattern;
  logic [CW-1:0]  bit_count;
  logic           loop;
  logic           stop;
  logic           w;
  logic           valid;
  logic           busy;
  logic           done;
  logic           err;
  logic [1:0]     cur_state;

  int n_cmp = 0;
  int n_err = 0;

  seq_pattern_gen #(.LEN(LEN), .CW(CW)) dut (
    .Clock    (clk),
    .Reset    (rst),
    .Start    (start),
    .Pattern  (pattern),
    .BitCount (bit_count),
    .Loop     (loop),
    .Stop     (stop),
    .w        (w),
    .Valid    (valid),
    .Busy     (busy),
    .Done     (done),
    .Err      (err),
    .CurState (cur_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {w, valid, busy, done, err, cur_state}
  function automatic logic [6:0] obs();
    return {w, valid, busy, done, err, cur_state};
  endfunction

  // Expected outputs k cycles after an accepted Start: n bits from the top of
  // pat repeated reps times, then one DONE cycle, then idle.
  function automatic logic [6:0] model_out(logic [LEN-1:0] pat, int n, int reps, int k);
    int total;
    int idx;
    total = n * reps;
    if (k >= 1 && k <= total) begin
      idx = (k - 1) % n;
      return {pat[LEN-1-idx], 1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
    end
    if (k == total + 1) return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10};
    return 7'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pattern = '0; bit_count = '0; loop = 1'b0; stop = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (obs() !== 7'd0) begin
      n_err++; $display("FAIL reset_hold got=%b exp=%b", obs(), 7'd0);
    end
    #3 rst = 1'b0;
    step();
    n_cmp++;
    if (obs() !== 7'd0) begin
      n_err++; $display("FAIL reset_release got=%b exp=%b", obs(), 7'd0);
    end
  endtask

  task automatic test_oneshot();
    logic [6:0] e;
    pattern = 8'b1101_0000; bit_count = 5'd4; loop = 1'b0; stop = 1'b0; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      start = 1'b0;
      e = model_out(8'b1101_0000, 4, 1, k);
      n_cmp++;
      if (obs() !== e) begin
        n_err++; $display("FAIL oneshot k=%0d got=%b exp=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_loop_stop();
    logic [6:0] e;
    int done_cnt;
    done_cnt = 0;
    pattern = 8'b1111_0000; bit_count = 5'd4; loop = 1'b1; stop = 1'b0; start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      start = 1'b0;
      loop = 1'b0;
      e = model_out(8'b1111_0000, 4, 3, k);
      if (done) done_cnt++;
      n_cmp++;
      if (obs() !== e) begin
        n_err++; $display("FAIL loop_stop k=%0d got=%b exp=%b", k, obs(), e);
      end
      stop = (k >= 9);
    end
    stop = 1'b0;
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++; $display("FAIL loop_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_err();
    logic [CW-1:0] bad [2];
    bad[0] = 5'd0;
    bad[1] = 5'd9;
    for (int i = 0; i < 2; i++) begin
      pattern = 8'hC3; bit_count = bad[i]; loop = 1'b0; stop = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      n_cmp++;
      if (obs() !== 7'b0000100) begin
        n_err++; $display("FAIL err_pulse cnt=%0d got=%b exp=%b", bad[i], obs(), 7'b0000100);
      end
      step();
      n_cmp++;
      if (obs() !== 7'd0) begin
        n_err++; $display("FAIL err_clear cnt=%0d got=%b exp=%b", bad[i], obs(), 7'd0);
      end
    end
  endtask

  task automatic test_ignore_inputs();
    logic [6:0] e;
    pattern = 8'hA5; bit_count = 5'd8; loop = 1'b0; stop = 1'b0; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      e = model_out(8'hA5, 8, 1, k);
      n_cmp++;
      if (obs() !== e) begin
        n_err++; $display("FAIL ignore_inputs k=%0d got=%b exp=%b", k, obs(), e);
      end
      if (k <= 8) begin
        start = 1'b1; pattern = 8'hFF; bit_count = 5'($urandom); loop = 1'b1;
      end else begin
        start = 1'b0; loop = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] e;
    pattern = 8'hAA; bit_count = 5'd8; loop = 1'b1; stop = 1'b0; start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      start = 1'b0;
      e = model_out(8'hAA, 8, 1, k);
      n_cmp++;
      if (obs() !== e) begin
        n_err++; $display("FAIL pre_reset k=%0d got=%b exp=%b", k, obs(), e);
      end
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 7'd0) begin
      n_err++; $display("FAIL async_reset got=%b exp=%b", obs(), 7'd0);
    end
    #2 rst = 1'b0;
    loop = 1'b0;
    step();
    n_cmp++;
    if (obs() !== 7'd0) begin
      n_err++; $display("FAIL post_reset_idle got=%b exp=%b", obs(), 7'd0);
    end
    pattern = 8'h3C; bit_count = 5'd5; start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      start = 1'b0;
      e = model_out(8'h3C, 5, 1, k);
      n_cmp++;
      if (obs() !== e) begin
        n_err++; $display("FAIL post_reset_txn k=%0d got=%b exp=%b", k, obs(), e);
      end
    end
  endtask

  // Behavioural "1111" detector fed from w while Valid is high
  task automatic test_detector_loopback();
    int  run;
    logic seen;
    run = 0; seen = 1'b0;
    pattern = 8'b1111_0000; bit_count = 5'd4; loop = 1'b0; stop = 1'b0; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      start = 1'b0;
      if (valid === 1'b1) begin
        run = (w === 1'b1) ? run + 1 : 0;
        if (run >= 4) seen = 1'b1;
      end
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_err++; $display("FAIL detector_loopback got=%b exp=1", seen);
    end
  endtask

  // Random back-to-back transactions; each new Start lands on the first idle cycle
  task automatic test_random();
    logic [LEN-1:0] pat;
    logic [6:0]     e;
    int n, t, reps, total;
    logic lp;
    for (int tr = 0; tr < 30; tr++) begin
      pat = LEN'($urandom);
      n   = $urandom_range(0, LEN + 1);
      lp  = 1'($urandom_range(0, 1));
      pattern = pat; bit_count = CW'(n); loop = lp; stop = 1'b0; start = 1'b1;
      if (n == 0 || n > LEN) begin
        step();
        start = 1'b0;
        n_cmp++;
        if (obs() !== 7'b0000100) begin
          n_err++; $display("FAIL rand_err tr=%0d got=%b exp=%b", tr, obs(), 7'b0000100);
        end
        step();
        n_cmp++;
        if (obs() !== 7'd0) begin
          n_err++; $display("FAIL rand_err_clear tr=%0d got=%b exp=%b", tr, obs(), 7'd0);
        end
      end else begin
        t     = $urandom_range(1, 3 * n);
        reps  = lp ? (t + n - 1) / n : 1;
        total = n * reps;
        for (int k = 1; k <= total + 2; k++) begin
          step();
          e = model_out(pat, n, reps, k);
          n_cmp++;
          if (obs() !== e) begin
            n_err++; $display("FAIL rand_txn tr=%0d k=%0d got=%b exp=%b", tr, k, obs(), e);
          end
          if (k <= total) begin
            start     = 1'($urandom_range(0, 1));
            pattern   = LEN'($urandom);
            bit_count = CW'($urandom);
            loop      = 1'($urandom_range(0, 1));
            stop      = lp ? (k >= t) : 1'($urandom_range(0, 1));
          end else begin
            start = 1'b0; stop = 1'b0; loop = 1'b0;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_loop_stop();
    test_err();
    test_ignore_inputs();
    test_async_reset();
    test_detector_loopback();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-pattern transmitter. Loads a parallel pattern and shifts it out one bit per clock on a single serial line, MSB first.
- Produces the serial `w` stimulus that the team's sequence-detector FSMs consume, so board demos and benches can drive detectors from a register rather than hand-toggled switches.
- Supports one-shot and continuous-loop transmission, with a start/busy/done handshake and a state readout for LEDs.

Parameters:
- LEN, 8, maximum pattern length in bits (2..16).
- CW, 5, counter width; must satisfy 2^CW > LEN.

Ports:
- Clock  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request transmission; sampled only in IDLE.
- Pattern  input  LEN  bits to send; Pattern[LEN-1] goes first.
- BitCount  input  CW  number of bits to send, taken from the top of Pattern; valid range 1..LEN.
- Loop  input  1  1 = repeat the pattern back-to-back until Stop; sampled with Start.
- Stop  input  1  end a looping transmission at the next pattern boundary.
- w  output  1  serial data bit.
- Valid  output  1  1 while w carries a pattern bit.
- Busy  output  1  1 in SHIFT and DONE.
- Done  output  1  one-cycle pulse after the final bit.
- Err  output  1  one-cycle pulse when Start is rejected for a bad BitCount.
- CurState  output  2  current state encoding.

Behaviour:
- Reset (async, any time, including mid-transmission):
  - state=IDLE, shift register=0, counter=0, loop flag=0, shadow pattern=0, shadow length=0.
  - Outputs: w=0, Valid=0, Busy=0, Done=0, Err=0, CurState=2'b00.
  - Release takes effect at the next rising edge; no partial bit is emitted.
- States and encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and recovers to IDLE on the next edge.
- IDLE:
  - Start=1 with 1<=BitCount<=LEN: load shreg<=Pattern, shadow<=Pattern, cnt<=BitCount, len_q<=BitCount, loop_q<=Loop; go to SHIFT.
  - Start=1 with BitCount=0 or BitCount>LEN: stay in IDLE; Err=1 for the following cycle.
  - Start=0: stay in IDLE.
- SHIFT:
  - Combinational outputs: w=shreg[LEN-1], Valid=1, Busy=1.
  - Each edge: shreg<=shreg<<1 (zero fill), cnt<=cnt-1.
  - Edge with cnt==1 (last bit):
    - If loop_q=1 and Stop=0: shreg<=shadow, cnt<=len_q, stay in SHIFT. No gap cycle; the first bit of the next repeat follows the last bit immediately.
    - Otherwise: go to DONE.
  - Stop asserted mid-pattern clears loop_q on that edge, so the current pattern always completes. Stop has no effect when Loop=0.
- DONE:
  - Outputs: Done=1, Busy=1, Valid=0, w=0.
  - Next edge goes to IDLE unconditionally.
- Start, Pattern, BitCount and Loop are ignored outside IDLE. Changing Pattern during SHIFT does not alter the bits being sent.
- Latency:
  - First bit appears in the cycle after the Start edge.
  - N bits occupy N cycles; Done follows in cycle N+1.
  - Next Start is accepted in cycle N+2.
- Outside SHIFT: w=0 and Valid=0.
- Counter arithmetic is unsigned CW-bit; cnt never wraps, because it is reloaded or left at 0 before it reaches 0 in SHIFT.

Test Plan:
- LEN=8, Pattern=8'b1101_0000, BitCount=4, Start pulse -> w=1,1,0,1 with Valid=1 for 4 cycles; Done=1 in cycle 5; IDLE in cycle 6.
- Pattern=8'b1111_0000, BitCount=4, Loop=1, then Stop raised during the 3rd repeat -> w=1 continuously for 12 cycles with Valid held; Done=1 exactly once, after the 12th bit.
- BitCount=0, Start=1, then BitCount=9, Start=1 -> Err pulses one cycle each; Busy stays 0; CurState=00.
- Start re-pulsed and Pattern changed to 8'hFF during SHIFT of 8'hA5, BitCount=8 -> w=1,0,1,0,0,1,0,1 unchanged; single Done.
- Reset asserted asynchronously mid-bit during SHIFT -> all outputs 0 and CurState=00 immediately, without waiting for an edge; after release a new Start transmits normally.
- Detector loopback: feed w into the team's sequence detector with Pattern=8'b1111_0000, BitCount=4 -> detector output rises while Valid is still 1.
